// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the instruction-memory loader: loader FSM states and
// the byte geometry of a memory word.
package riscv_mem_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    CHECK,
    DONE
  } loader_state_t;

endpackage

// File: rtl/byte_word_packer.sv
// Little-endian byte-to-word packer: each accepted byte shifts in from the top,
// so the first byte ends up in bits [7:0] once the word is complete.
module byte_word_packer
  import riscv_mem_pkg::*;
#(
  parameter int WORD_WIDTH = 8 * BYTES_PER_WORD
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  clear,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  word_complete
);

  logic [BYTE_CNT_W-1:0] byte_cnt;

  // clear wins over a byte so a discarded partial word never leaks into the next one
  always_ff @(posedge CLK) begin
    if (!RST_N || clear) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 1'b1;
      word     <= {byte_data, word[WORD_WIDTH-1:8]};
    end
  end

  assign word_complete = byte_valid && (byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a little-endian byte stream into instruction memory, one word per write.
// Optional trailing-checksum verification is enabled with IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import riscv_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  chk_err
);

  localparam logic [ADDR_WIDTH:0] ONE_WORD = 1;

  loader_state_t state, state_next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remain_q;
  logic                  start_ok;
  logic                  byte_fire;
  logic                  packer_clear;
  logic                  word_complete;
  logic [DATA_WIDTH-1:0] packed_word;

  assign start_ok  = (state == IDLE) && start;
  assign byte_fire = s_valid && s_ready;

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign s_ready = (state == COLLECT) || (state == CHECK);
`else
  assign s_ready = (state == COLLECT);
`endif

  byte_word_packer #(
    .WORD_WIDTH(DATA_WIDTH)
  ) u_packer (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .clear        (packer_clear),
    .byte_valid   (byte_fire),
    .byte_data    (s_data),
    .word         (packed_word),
    .word_complete(word_complete)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      addr_q   <= '0;
      remain_q <= '0;
    end else if (start_ok) begin
      addr_q   <= base_addr;
      remain_q <= word_count;
    end else if (state == WRITE) begin
      addr_q   <= addr_q + 1'b1;
      remain_q <= remain_q - 1'b1;
    end
  end

  always_comb begin
    state_next   = state;
    we           = 1'b0;
    done         = 1'b0;
    packer_clear = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          packer_clear = 1'b1;
          state_next   = (word_count == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        if (word_complete) state_next = WRITE;
      end
      WRITE: begin
        we           = 1'b1;
        packer_clear = 1'b1;
        if (remain_q != ONE_WORD) begin
          state_next = COLLECT;
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = DONE;
`endif
        end
      end
      CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (word_complete) state_next = DONE;
`else
        state_next = DONE;
`endif
      end
      DONE: begin
        done         = 1'b1;
        packer_clear = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // busy rises combinationally with the accepted start so a zero-length load still shows it
  assign busy  = RST_N && (start_ok || (state == COLLECT) || (state == WRITE) || (state == CHECK));
  assign waddr = addr_q;
  assign wdata = packed_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q;
  logic                  chk_err_q;

  // the trailer is compared as it completes, so chk_err is already valid alongside done
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sum_q     <= '0;
      chk_err_q <= 1'b0;
    end else if (start_ok) begin
      sum_q     <= '0;
      chk_err_q <= 1'b0;
    end else begin
      if (state == WRITE) sum_q <= sum_q + packed_word;
      if ((state == CHECK) && word_complete)
        chk_err_q <= ({s_data, packed_word[DATA_WIDTH-1:8]} != sum_q);
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning memory word width (fixed at 4 bytes).
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, meaning the word address width of the target instruction memory.
REQ-003 SHALL have port CLK  input  1  rising-edge clock; the block uses one clock; reset is synchronous and active-low.
REQ-004 SHALL have port RST_N  input  1  synchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle load request, sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  ADDR_WIDTH  first word address, captured on an accepted start.
REQ-007 SHALL have port word_count  input  ADDR_WIDTH+1  number of words to load, captured on an accepted start.
REQ-008 SHALL have port s_valid  input  1  byte-stream valid.
REQ-009 SHALL have port s_data  input  8  byte-stream data.
REQ-010 SHALL have port s_ready  output  1  byte-stream ready; a byte transfers when s_valid and s_ready are both high at a rising edge.
REQ-011 SHALL have port we  output  1  memory write strobe.
REQ-012 SHALL have port waddr  output  ADDR_WIDTH  memory write address.
REQ-013 SHALL have port wdata  output  DATA_WIDTH  memory write data.
REQ-014 SHALL have port busy  output  1  high from an accepted start until done.
REQ-015 SHALL have port done  output  1  one-cycle pulse at load completion.
REQ-016 SHALL have port chk_err  output  1  checksum mismatch flag, valid with done.

Function
REQ-017 SHALL implement FSM states IDLE, COLLECT, WRITE, CHECK, DONE.
REQ-018 IDLE SHALL go to COLLECT on start when word_count>0, and to DONE when word_count==0; a start outside IDLE SHALL be ignored.
REQ-019 COLLECT SHALL drive s_ready=1 and pack bytes little-endian: first byte to wdata[7:0], fourth byte to wdata[31:24].
REQ-020 The cycle after the fourth byte transfers SHALL be WRITE, with we=1 for exactly one cycle, s_ready=0, and waddr equal to the current word address.
REQ-021 After WRITE, the word address SHALL increment modulo 2**ADDR_WIDTH, so base 0x3FF followed by a second word wraps to 0x000.
REQ-022 After WRITE, the remaining count SHALL decrement; the next state SHALL be COLLECT if the count is nonzero, otherwise CHECK when the checksum feature is compiled in, otherwise DONE.
REQ-023 DONE SHALL pulse done=1 for one cycle, deassert busy in that same cycle, and return to IDLE.
REQ-024 A gap in s_valid SHALL stall COLLECT indefinitely, with no timeout and no loss of a partial word.
REQ-025 we SHALL never assert outside WRITE, and s_ready SHALL be 0 in every state except COLLECT/CHECK.

Reset
REQ-026 RST_N=0 at a rising edge SHALL force IDLE, with s_ready, we, busy, done and chk_err at 0 and waddr and wdata at 0.
REQ-027 Reset during a load SHALL discard any partial word, issue no further writes, and produce no done pulse.

Configuration
REQ-028 With IMEM_LOADER_CHECKSUM_EN defined, the block SHALL keep a 32-bit wrap-around sum of all written words; in CHECK it SHALL accept one extra 4-byte little-endian word (not written to memory) and set chk_err=1 with done if that word differs from the sum; chk_err SHALL hold until the next accepted start.
REQ-029 Without IMEM_LOADER_CHECKSUM_EN, CHECK SHALL be unreachable, no trailing word SHALL be consumed, and chk_err SHALL be tied to 0.

Structure
REQ-030 The FSM state enum and the bytes-per-word constant (4) SHALL live in the shared package riscv_mem_pkg.
REQ-031 The byte-to-word packer (byte counter plus shift register, with a clear input) SHALL be a sub-module named byte_word_packer.

Verification
REQ-032 Bench SHALL cover: base_addr=0x010, word_count=2, bytes 13 00 00 00 93 00 10 00 -> we at 0x010 with 0x00000013, then at 0x011 with 0x00100093, then one done pulse.
REQ-033 Bench SHALL cover: base_addr=0x3FF, word_count=2 -> writes at 0x3FF then 0x000.
REQ-034 Bench SHALL cover: word_count=0 -> done one cycle after busy rises, zero writes, s_ready never high.
REQ-035 Bench SHALL cover: s_valid deasserted for 5 cycles after byte 2 -> same wdata as without the gap, write delayed 5 cycles.
REQ-036 Bench SHALL cover: RST_N low after 3 bytes, then a new load of word 0xDEADBEEF -> single write of 0xDEADBEEF, no stale bytes in it.
REQ-037 With IMEM_LOADER_CHECKSUM_EN, bench SHALL cover: words 1 and 2 with trailer 3 -> chk_err=0; trailer 4 -> chk_err=1 with done.
